// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, special instructions, fetch FSM states.
// Pure declarations, no logic and no latency.
// No flow control lives here; consumers apply their own handshakes.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_LDR = 4'h4;
  localparam logic [3:0] OP_STR = 4'h5;
  localparam logic [3:0] OP_BRN = 4'h8;
  localparam logic [3:0] OP_LDI = 4'hD;

  localparam logic [7:0] INSTR_HALT = 8'hFF;
  localparam logic [7:0] INSTR_NOP  = 8'h00;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // The fetch unit only needs to recognise HALT; everything else passes through.
  function automatic logic is_halt(input logic [7:0] instr);
    return instr == INSTR_HALT;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter: holds, increments (wrapping FF->00) or loads a new target.
// Latency: new value visible one clk edge after inc_i/load_i.
// No backpressure; load_i wins over inc_i when both are asserted.
module fetch_pc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic [7:0] pc_o
);

  logic [7:0] pc_q;
  logic [7:0] pc_d;

  // Next pc: redirect first, then sequential step; 8-bit add wraps silently.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + 8'd1;
    end
  end

  // pc register, cleared to address 0 on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 8'h00;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads imem at pc, holds the byte in ir and offers it to execute.
// Latency: first instr_valid one edge after reset release, two edges after a branch; then 1 instr/cycle.
// Backpressure: instr_ready low holds ir/ir_pc/pc; branch_valid overrides any accept.
// Optional: define INSTR_FETCH_PERF_EN to add the saturating fetch_cnt output.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] ir,
  output logic [7:0] ir_pc,
  output logic [3:0] opcode,
  output logic [3:0] operand,
  input  logic       branch_valid,
  input  logic [7:0] branch_target,
  output logic       halted
`ifdef INSTR_FETCH_PERF_EN
  ,
  output logic [15:0] fetch_cnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [7:0]   ir_q, ir_d;
  logic [7:0]   ir_pc_q, ir_pc_d;
  logic [7:0]   pc;
  logic         pc_inc;
  logic         pc_load;
  logic         accept;

  fetch_pc u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (pc_inc),
    .load_i     (pc_load),
    .load_val_i (branch_target),
    .pc_o       (pc)
  );

  // A held instruction is consumed only when execute is ready and not redirecting us.
  assign accept = (state_q == ST_ISSUE) && instr_ready && !branch_valid;

  // FSM and ir next-state: branches discard ir, accepts refill ir from imem in the same edge.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (branch_valid) begin
          pc_load = 1'b1;
        end else begin
          ir_d    = imem_data;
          ir_pc_d = pc;
          pc_inc  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (branch_valid) begin
          pc_load = 1'b1;
          state_d = ST_FETCH;
        end else if (accept) begin
          if (is_halt(ir_q)) begin
            state_d = ST_HALTED;
          end else begin
            ir_d    = imem_data;
            ir_pc_d = pc;
            pc_inc  = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        // Only reset leaves this state.
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // State and instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      ir_q    <= INSTR_NOP;
      ir_pc_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Count accepted instructions, sticking at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fetch_cnt = cnt_q;
`endif

  assign imem_addr   = pc;
  assign instr_valid = (state_q == ST_ISSUE);
  assign halted      = (state_q == ST_HALTED);
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign opcode      = ir_q[7:4];
  assign operand     = ir_q[3:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized ready/branch traffic
// compared against a transaction-level model of the fetch rules.
// Build with INSTR_FETCH_PERF_EN defined to also check fetch_cnt.
module tb_instr_fetch;

  logic       clk;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] ir;
  logic [7:0] ir_pc;
  logic [3:0] opcode;
  logic [3:0] operand;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic       halted;
`ifdef INSTR_FETCH_PERF_EN
  logic [15:0] fetch_cnt;
`endif

  logic [7:0] mem [256];

  int checks;
  int passed;

  // Reference model state: next fetch address, held instruction, halt flag, accept count.
  logic [7:0] m_pc;
  logic       m_valid;
  logic [7:0] m_ir;
  logic [7:0] m_irpc;
  logic       m_halt;
  int         m_cnt;

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .opcode        (opcode),
    .operand       (operand),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halted        (halted)
`ifdef INSTR_FETCH_PERF_EN
    ,
    .fetch_cnt     (fetch_cnt)
`endif
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc    = 8'h00;
    m_valid = 1'b0;
    m_ir    = 8'h00;
    m_irpc  = 8'h00;
    m_halt  = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_fetch();
    m_ir    = mem[m_pc];
    m_irpc  = m_pc;
    m_pc    = m_pc + 8'd1;
    m_valid = 1'b1;
  endtask

  // One clock edge of the fetch rules.
  task automatic model_edge(input logic r, input logic b, input logic [7:0] t);
    if (m_halt) return;
    if (b) begin
      m_pc    = t;
      m_valid = 1'b0;
    end else if (!m_valid) begin
      model_fetch();
    end else if (r) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_ir == 8'hFF) begin
        m_halt  = 1'b1;
        m_valid = 1'b0;
      end else begin
        model_fetch();
      end
    end
  endtask

  // Drive inputs for one cycle, advance the model at the edge, return at the next negedge.
  task automatic tick(input logic r, input logic b, input logic [7:0] t);
    instr_ready   = r;
    branch_valid  = b;
    branch_target = t;
    @(posedge clk);
    model_edge(r, b, t);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0;
    branch_valid = 1'b0;
    branch_target = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %h want 0", instr_valid); else passed++;
    checks++; if (halted !== 1'b0) $display("FAIL reset_halted got %h want 0", halted); else passed++;
    checks++; if (imem_addr !== 8'h00) $display("FAIL reset_pc got %h want 00", imem_addr); else passed++;
    checks++; if (ir !== 8'h00) $display("FAIL reset_ir got %h want 00", ir); else passed++;
    checks++; if (ir_pc !== 8'h00) $display("FAIL reset_ir_pc got %h want 00", ir_pc); else passed++;
`ifdef INSTR_FETCH_PERF_EN
    checks++; if (fetch_cnt !== 16'h0) $display("FAIL reset_cnt got %h want 0", fetch_cnt); else passed++;
`endif
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    tick(1'b1, 1'b0, 8'h00);
    checks++; if (instr_valid !== 1'b1) $display("FAIL stream_first_valid got %h want 1", instr_valid); else passed++;
    checks++; if (ir !== 8'hD4) $display("FAIL stream_ir0 got %h want D4", ir); else passed++;
    checks++; if (ir_pc !== 8'h00) $display("FAIL stream_ir_pc0 got %h want 00", ir_pc); else passed++;
    checks++; if ({opcode, operand} !== 8'hD4) $display("FAIL stream_decode got %h%h want D4", opcode, operand); else passed++;
    tick(1'b1, 1'b0, 8'h00);
    checks++; if (ir !== 8'h50) $display("FAIL stream_ir1 got %h want 50", ir); else passed++;
    checks++; if (ir_pc !== 8'h01) $display("FAIL stream_ir_pc1 got %h want 01", ir_pc); else passed++;
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 8'h00);
      checks++; if (ir !== 8'h50) $display("FAIL stall_ir cyc%0d got %h want 50", i, ir); else passed++;
      checks++; if (ir_pc !== 8'h01) $display("FAIL stall_ir_pc cyc%0d got %h want 01", i, ir_pc); else passed++;
      checks++; if (imem_addr !== 8'h02) $display("FAIL stall_addr cyc%0d got %h want 02", i, imem_addr); else passed++;
      checks++; if (instr_valid !== 1'b1) $display("FAIL stall_valid cyc%0d got %h want 1", i, instr_valid); else passed++;
    end
    tick(1'b1, 1'b0, 8'h00);
    checks++; if (ir !== 8'h51) $display("FAIL stall_release_ir got %h want 51", ir); else passed++;
    checks++; if (ir_pc !== 8'h02) $display("FAIL stall_release_ir_pc got %h want 02", ir_pc); else passed++;
`ifdef INSTR_FETCH_PERF_EN
    checks++; if (fetch_cnt !== m_cnt[15:0]) $display("FAIL stall_cnt got %0d want %0d", fetch_cnt, m_cnt); else passed++;
`endif
  endtask

  task automatic test_branch();
    tick(1'b0, 1'b1, 8'h26);
    checks++; if (instr_valid !== 1'b0) $display("FAIL branch_bubble1 got %h want 0", instr_valid); else passed++;
    tick(1'b0, 1'b0, 8'h00);
    checks++; if (ir !== 8'h83 || ir_pc !== 8'h26) $display("FAIL branch_setup got %h@%h want 83@26", ir, ir_pc); else passed++;
    tick(1'b1, 1'b1, 8'h29);
    checks++; if (instr_valid !== 1'b0) $display("FAIL branch_discard_valid got %h want 0", instr_valid); else passed++;
    checks++; if (imem_addr !== 8'h29) $display("FAIL branch_addr got %h want 29", imem_addr); else passed++;
`ifdef INSTR_FETCH_PERF_EN
    checks++; if (fetch_cnt !== m_cnt[15:0]) $display("FAIL branch_cnt got %0d want %0d", fetch_cnt, m_cnt); else passed++;
`endif
    tick(1'b0, 1'b0, 8'h00);
    checks++; if (instr_valid !== 1'b1) $display("FAIL branch_target_valid got %h want 1", instr_valid); else passed++;
    checks++; if (ir !== 8'hA7 || ir_pc !== 8'h29) $display("FAIL branch_target_ir got %h@%h want A7@29", ir, ir_pc); else passed++;
  endtask

  task automatic test_halt();
    tick(1'b0, 1'b1, 8'h60);
    tick(1'b0, 1'b0, 8'h00);
    checks++; if (ir !== 8'hFF || instr_valid !== 1'b1) $display("FAIL halt_setup got %h v%h want FF v1", ir, instr_valid); else passed++;
    tick(1'b1, 1'b0, 8'h00);
    checks++; if (halted !== 1'b1) $display("FAIL halt_flag got %h want 1", halted); else passed++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL halt_valid got %h want 0", instr_valid); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 8'h10);
      checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) $display("FAIL halt_sticky cyc%0d got h%h v%h want h1 v0", i, halted, instr_valid); else passed++;
      checks++; if (imem_addr !== 8'h61) $display("FAIL halt_pc cyc%0d got %h want 61", i, imem_addr); else passed++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (halted !== 1'b0) $display("FAIL halt_async_reset got %h want 0", halted); else passed++;
    checks++; if (ir_pc !== 8'h00 || imem_addr !== 8'h00) $display("FAIL halt_reset_pc got %h/%h want 00/00", ir_pc, imem_addr); else passed++;
    rst_n = 1'b1;
    model_reset();
    tick(1'b0, 1'b0, 8'h00);
    checks++; if (instr_valid !== 1'b1 || ir !== 8'hD4 || ir_pc !== 8'h00) $display("FAIL halt_restart got v%h %h@%h want v1 D4@00", instr_valid, ir, ir_pc); else passed++;
  endtask

  task automatic test_wrap();
    tick(1'b0, 1'b1, 8'hFF);
    tick(1'b0, 1'b0, 8'h00);
    checks++; if (ir !== 8'h00 || ir_pc !== 8'hFF) $display("FAIL wrap_nop got %h@%h want 00@FF", ir, ir_pc); else passed++;
    checks++; if (imem_addr !== 8'h00) $display("FAIL wrap_addr got %h want 00", imem_addr); else passed++;
    tick(1'b1, 1'b0, 8'h00);
    checks++; if (ir !== 8'hD4 || ir_pc !== 8'h00) $display("FAIL wrap_next got %h@%h want D4@00", ir, ir_pc); else passed++;
    checks++; if (imem_addr !== 8'h01) $display("FAIL wrap_addr2 got %h want 01", imem_addr); else passed++;
`ifdef INSTR_FETCH_PERF_EN
    checks++; if (fetch_cnt !== m_cnt[15:0]) $display("FAIL wrap_cnt got %0d want %0d", fetch_cnt, m_cnt); else passed++;
`endif
  endtask

  task automatic test_random();
    logic       r;
    logic       b;
    logic [7:0] t;
    for (int a = 0; a < 256; a++) begin
      mem[a] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom);
    end
    for (int i = 0; i < 600; i++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        model_reset();
      end
      r = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 9) == 0);
      t = 8'($urandom);
      tick(r, b, t);
      checks++; if (instr_valid !== m_valid) $display("FAIL rand_valid cyc%0d got %h want %h", i, instr_valid, m_valid); else passed++;
      checks++; if (halted !== m_halt) $display("FAIL rand_halted cyc%0d got %h want %h", i, halted, m_halt); else passed++;
      checks++; if (imem_addr !== m_pc) $display("FAIL rand_addr cyc%0d got %h want %h", i, imem_addr, m_pc); else passed++;
      if (m_valid) begin
        checks++; if (ir !== m_ir || ir_pc !== m_irpc) $display("FAIL rand_ir cyc%0d got %h@%h want %h@%h", i, ir, ir_pc, m_ir, m_irpc); else passed++;
      end
`ifdef INSTR_FETCH_PERF_EN
      checks++; if (fetch_cnt !== m_cnt[15:0]) $display("FAIL rand_cnt cyc%0d got %0d want %0d", i, fetch_cnt, m_cnt); else passed++;
`endif
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'h00] = 8'hD4;
    mem[8'h01] = 8'h50;
    mem[8'h02] = 8'h51;
    mem[8'h26] = 8'h83;
    mem[8'h29] = 8'hA7;
    mem[8'h60] = 8'hFF;
    mem[8'h61] = 8'h12;
    mem[8'hFF] = 8'h00;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_halt();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The design SHALL use one clock and an asynchronous, active-low reset: clk is the single clock and rst_n is the reset, asserted at 0.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 imem_addr  output  8  instruction memory address; equals pc combinationally.
REQ-005 imem_data  input  8  instruction byte; combinational response to imem_addr in the same cycle.
REQ-006 instr_valid  output  1  ir holds an instruction offered to the execute stage.
REQ-007 instr_ready  input  1  execute stage accepts ir this cycle.
REQ-008 ir  output  8  held instruction byte.
REQ-009 ir_pc  output  8  address ir was fetched from.
REQ-010 opcode  output  4  ir[7:4]; operand  output  4  ir[3:0].
REQ-011 branch_valid  input  1  redirect request from execute; branch_target  input  8  new pc.
REQ-012 halted  output  1  HALT instruction accepted; fetch stopped.

Function
REQ-013 States SHALL be FETCH, ISSUE and HALTED.
REQ-014 In FETCH, each edge: ir<=imem_data, ir_pc<=pc, pc<=pc+1, state<=ISSUE.
REQ-015 instr_valid SHALL be 1 exactly when state is ISSUE.
REQ-016 Accept = instr_valid & instr_ready & ~branch_valid.
REQ-017 In ISSUE without accept or branch, ir, ir_pc and pc SHALL hold.
REQ-018 In ISSUE on accept with ir != 8'hFF: load the next instruction as in REQ-014 and stay in ISSUE, so throughput is one instruction per cycle.
REQ-019 In ISSUE on accept with ir == 8'hFF: state<=HALTED, pc holds.
REQ-020 branch_valid in FETCH or ISSUE SHALL take priority: the held ir is discarded (not accepted), pc<=branch_target, state<=FETCH.
REQ-021 branch_valid and instr_ready in the same cycle: branch wins, no accept.
REQ-022 pc+1 SHALL wrap 8'hFF->8'h00 with no flag.
REQ-023 In HALTED: halted=1 and instr_valid=0; branch_valid and instr_ready are ignored; exit only by reset.
REQ-024 Opcode 8'h00 (NOP) SHALL be issued like any other instruction; the unit decodes only HALT.
REQ-025 Latency: first instr_valid SHALL appear one clock edge after rst_n deasserts; after a branch, two edges.

Reset
REQ-026 Reset SHALL set state=FETCH, pc=0, ir=0, ir_pc=0, instr_valid=0, halted=0, perf count=0.
REQ-027 Reset asserted mid-operation, including in HALTED, SHALL take effect immediately regardless of clk, with no residual instruction issued.

Configuration
REQ-028 Macro INSTR_FETCH_PERF_EN, when defined, SHALL add output fetch_cnt [15:0], counting accepted instructions (saturating at 16'hFFFF, reset to 0).
REQ-029 Without INSTR_FETCH_PERF_EN, fetch_cnt and its counter SHALL be absent, and all other behaviour is identical.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the opcode constants (OP_ADD=4'h1, OP_SUB=4'h2, OP_LDR=4'h4, OP_STR=4'h5, OP_BRN=4'h8, OP_LDI=4'hD), INSTR_HALT=8'hFF, INSTR_NOP=8'h00, and the fetch-state enum.
REQ-031 The pc register with its increment, wrap and load SHALL be one sub-module, fetch_pc; the FSM and ir live in instr_fetch.

Verification
REQ-032 Reset release, memory 0:D4 1:50 2:51, instr_ready=1 -> instr_valid on edge 1; ir D4, 50, 51 on consecutive cycles, with ir_pc 0, 1, 2.
REQ-033 instr_ready=0 for 3 cycles while ir=50 -> ir=50, ir_pc=1 and imem_addr=2 stay stable; on the ready cycle the next ir is 51.
REQ-034 Held ir=83 at ir_pc=26, branch_valid=1, target=29, instr_ready=1 in the same cycle -> 83 not accepted; next cycle instr_valid=0; following cycle ir=memory[29], ir_pc=29.
REQ-035 Program reaching FF at address 60, accepted -> halted=1 and instr_valid=0 from the next cycle; later branch_valid=1 is ignored; rst_n pulse returns ir_pc to 0 and clears halted.
REQ-036 branch_target=8'hFF, memory FF:00, 00:D4 -> ir_pc FF then 00 (wrap); with INSTR_FETCH_PERF_EN, fetch_cnt increments by exactly 1 per accept and 0 on stalls and branch cycles.
